// File: rtl/rob_multiport.sv
// rob_multiport - circular in-order reorder buffer with configurable dispatch
// width, retire width and completion-port count.
//
// Dispatch allocates up to DISPATCH_W entries per cycle at the tail and hands
// back their ROB indices. Completion ports mark entries done by ROB index.
// The retire stage drains up to RETIRE_W oldest contiguous complete entries
// per cycle when retire_en is high. A mispredict squash rolls the tail back to
// just after squash_idx and drops any dispatch offered in the same cycle.
//
// Ports:
//   clock, reset           clock; asynchronous active-low reset
//   dispatch_num/_data     entries offered this cycle (lane 0 oldest) + payloads
//   dispatch_idx           ROB index for each lane: (tail+i) mod DEPTH
//   free_slots/full/empty  occupancy from registered count only
//   complete_valid/_idx    per-port completion strobe and ROB index
//   squash_valid/_idx      mispredict recovery; squash_idx survives
//   retire_en              retire stage may accept this cycle
//   retire_num/_data       entries retiring now, oldest in lane 0, rest zero
//
// Optional build macro ROB_PERF_EN adds saturating 32-bit counters
// perf_retired, perf_full_cycles and perf_squashed.
module rob_multiport #(
    parameter int DEPTH      = 32,
    parameter int DISPATCH_W = 3,
    parameter int RETIRE_W   = 3,
    parameter int CDB_W      = 3,
    parameter int PAYLOAD_W  = 64,
    parameter int IDX_W      = $clog2(DEPTH),
    localparam int DN_W      = $clog2(DISPATCH_W + 1),
    localparam int RN_W      = $clog2(RETIRE_W + 1),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [DN_W-1:0]                 dispatch_num,
    input  logic [DISPATCH_W*PAYLOAD_W-1:0] dispatch_data,
    output logic [DISPATCH_W*IDX_W-1:0]     dispatch_idx,
    output logic [CNT_W-1:0]                free_slots,
    output logic                            full,
    output logic                            empty,
    input  logic [CDB_W-1:0]                complete_valid,
    input  logic [CDB_W*IDX_W-1:0]          complete_idx,
    input  logic                            squash_valid,
    input  logic [IDX_W-1:0]                squash_idx,
    input  logic                            retire_en,
    output logic [RN_W-1:0]                 retire_num,
    output logic [RETIRE_W*PAYLOAD_W-1:0]   retire_data
`ifdef ROB_PERF_EN
    ,
    output logic [31:0]                     perf_retired,
    output logic [31:0]                     perf_full_cycles,
    output logic [31:0]                     perf_squashed
`endif
);

    logic [IDX_W-1:0]     r_head;
    logic [IDX_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_complete;
    logic [PAYLOAD_W-1:0] r_payload [DEPTH];

    logic [DEPTH-1:0]     w_valid_nxt;
    logic [DEPTH-1:0]     w_complete_nxt;
    logic [DEPTH-1:0]     w_sq_mask;
    logic [IDX_W-1:0]     w_squashed;
    logic [IDX_W-1:0]     w_slot;
    logic [IDX_W-1:0]     w_rslot;
    logic                 w_run;
    logic                 w_disp_ok;
    logic [DN_W-1:0]      w_disp_num;

    // Occupancy status; derived from the registered count, never from head==tail.
    assign free_slots = CNT_W'(DEPTH) - r_count;
    assign full       = (r_count == CNT_W'(DEPTH));
    assign empty      = (r_count == {CNT_W{1'b0}});

    // A dispatch that does not fit is dropped whole; a squash drops it too.
    assign w_disp_ok  = !squash_valid && (CNT_W'(dispatch_num) <= free_slots);
    assign w_disp_num = w_disp_ok ? dispatch_num : {DN_W{1'b0}};

    // Index offered to each dispatch lane.
    always_comb begin
        dispatch_idx = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            dispatch_idx[i*IDX_W +: IDX_W] = r_tail + IDX_W'(i);
        end
    end

    // Retire: contiguous valid&complete run from head, from registered state only.
    always_comb begin
        retire_num  = '0;
        retire_data = '0;
        w_run       = 1'b1;
        w_rslot     = '0;
        for (int j = 0; j < RETIRE_W; j++) begin
            w_rslot = r_head + IDX_W'(j);
            if (retire_en && w_run && r_valid[w_rslot] && r_complete[w_rslot]) begin
                retire_num = retire_num + RN_W'(1);
                retire_data[j*PAYLOAD_W +: PAYLOAD_W] = r_payload[w_rslot];
            end else begin
                w_run = 1'b0;
            end
        end
    end

    // Per-entry valid/complete next state: complete, then retire, squash, dispatch.
    always_comb begin
        w_squashed     = r_tail - squash_idx - IDX_W'(1);
        w_sq_mask      = '0;
        w_valid_nxt    = r_valid;
        w_complete_nxt = r_complete;
        w_slot         = '0;
        // Entries strictly younger than squash_idx, up to tail-1.
        for (int e = 0; e < DEPTH; e++) begin
            if (squash_valid && ((IDX_W'(e) - squash_idx - IDX_W'(1)) < w_squashed)) begin
                w_sq_mask[e] = 1'b1;
            end else begin
                w_sq_mask[e] = 1'b0;
            end
        end
        for (int p = 0; p < CDB_W; p++) begin
            w_slot = complete_idx[p*IDX_W +: IDX_W];
            if (complete_valid[p] && r_valid[w_slot] && !w_sq_mask[w_slot]) begin
                w_complete_nxt[w_slot] = 1'b1;
            end else begin
                w_complete_nxt[w_slot] = w_complete_nxt[w_slot];
            end
        end
        for (int j = 0; j < RETIRE_W; j++) begin
            w_slot = r_head + IDX_W'(j);
            if (RN_W'(j) < retire_num) begin
                w_valid_nxt[w_slot]    = 1'b0;
                w_complete_nxt[w_slot] = 1'b0;
            end else begin
                w_valid_nxt[w_slot]    = w_valid_nxt[w_slot];
            end
        end
        w_valid_nxt    = w_valid_nxt & ~w_sq_mask;
        w_complete_nxt = w_complete_nxt & ~w_sq_mask;
        for (int i = 0; i < DISPATCH_W; i++) begin
            w_slot = r_tail + IDX_W'(i);
            if (w_disp_ok && (DN_W'(i) < dispatch_num)) begin
                w_valid_nxt[w_slot]    = 1'b1;
                w_complete_nxt[w_slot] = 1'b0;
            end else begin
                w_valid_nxt[w_slot]    = w_valid_nxt[w_slot];
            end
        end
    end

    // Pointer, count, entry-flag and payload state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_valid    <= '0;
            r_complete <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_payload[e] <= '0;
            end
        end else begin
            r_head     <= r_head + IDX_W'(retire_num);
            r_tail     <= squash_valid ? (squash_idx + IDX_W'(1)) : (r_tail + IDX_W'(w_disp_num));
            r_count    <= r_count + CNT_W'(w_disp_num) - CNT_W'(retire_num)
                          - (squash_valid ? CNT_W'(w_squashed) : {CNT_W{1'b0}});
            r_valid    <= w_valid_nxt;
            r_complete <= w_complete_nxt;
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (w_disp_ok && (DN_W'(i) < dispatch_num)) begin
                    r_payload[r_tail + IDX_W'(i)] <= dispatch_data[i*PAYLOAD_W +: PAYLOAD_W];
                end
            end
        end
    end

`ifdef ROB_PERF_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_full_cycles;
    logic [31:0] r_perf_squashed;
    logic [32:0] w_ret_sum;
    logic [32:0] w_sq_sum;

    // One extra bit catches overflow so the counters stick at all-ones.
    assign w_ret_sum = {1'b0, r_perf_retired} + 33'(retire_num);
    assign w_sq_sum  = {1'b0, r_perf_squashed} + (squash_valid ? 33'(w_squashed) : 33'd0);

    // Saturating performance counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_retired     <= 32'd0;
            r_perf_full_cycles <= 32'd0;
            r_perf_squashed    <= 32'd0;
        end else begin
            r_perf_retired  <= w_ret_sum[32] ? 32'hFFFF_FFFF : w_ret_sum[31:0];
            r_perf_squashed <= w_sq_sum[32]  ? 32'hFFFF_FFFF : w_sq_sum[31:0];
            if (full && (r_perf_full_cycles != 32'hFFFF_FFFF)) begin
                r_perf_full_cycles <= r_perf_full_cycles + 32'd1;
            end
        end
    end

    assign perf_retired     = r_perf_retired;
    assign perf_full_cycles = r_perf_full_cycles;
    assign perf_squashed    = r_perf_squashed;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
- Parametrised successor to the single-configuration ROB.
- Circular in-order reorder buffer with independent dispatch width, retire width and completion-port count.
- Completion is by ROB index, not by physical tag.
- Adds branch-mispredict squash (tail rollback) and a retire enable.
- Sits between dispatch (allocates entries, receives ROB indices) and the retire stage (updates arch map table and free list).

Parameters:
- DEPTH, 32: entry count; power of two, at least 2*max(DISPATCH_W,RETIRE_W).
- DISPATCH_W, 3: entries allocatable per cycle.
- RETIRE_W, 3: entries retirable per cycle.
- CDB_W, 3: completion ports per cycle.
- PAYLOAD_W, 64: opaque entry payload width (T, Told, arch reg, PC, etc.).
- IDX_W, $clog2(DEPTH): ROB index width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- dispatch_num  in  $clog2(DISPATCH_W+1)  entries offered this cycle, lanes 0..num-1, lane 0 oldest.
- dispatch_data  in  DISPATCH_W*PAYLOAD_W  per-lane payload.
- dispatch_idx  out  DISPATCH_W*IDX_W  ROB index assigned to each lane: (tail+i) mod DEPTH.
- free_slots  out  $clog2(DEPTH+1)  DEPTH-count; registered state only, excludes same-cycle retire.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- complete_valid  in  CDB_W  per-port completion strobe.
- complete_idx  in  CDB_W*IDX_W  ROB index completing.
- squash_valid  in  1  mispredict recovery.
- squash_idx  in  IDX_W  youngest surviving entry (the branch).
- retire_en  in  1  retire stage may accept.
- retire_num  out  $clog2(RETIRE_W+1)  entries retiring this cycle.
- retire_data  out  RETIRE_W*PAYLOAD_W  lanes 0..retire_num-1 valid, oldest first; others zero.

Behaviour:
- State: head, tail (IDX_W), count ($clog2(DEPTH+1)), per-entry valid/complete/payload.
- Reset (asynchronous, active-low): head=tail=count=0; all valid/complete cleared.
- Output reset values: free_slots=DEPTH, empty=1, full=0, retire_num=0, retire_data=0.
- Retire: combinational from registered state.
  - retire_num = length of the contiguous valid&complete run starting at head, capped at RETIRE_W; 0 when retire_en=0.
  - Retired entries are cleared at the clock edge; head advances by retire_num mod DEPTH.
- Dispatch:
  - Accepted when dispatch_num <= free_slots and squash_valid=0.
  - Entries written at (tail+i) mod DEPTH with valid=1, complete=0; tail advances by dispatch_num.
  - dispatch_num > free_slots is a protocol violation; the block accepts none.
  - Same-cycle retire does not create space for that cycle's dispatch; it appears in free_slots next cycle.
- Completion:
  - Each valid port sets complete on its entry at the next edge, if that entry is valid and not being squashed.
  - Completion to an invalid entry is ignored.
  - Duplicate indices across ports are harmless.
- Squash:
  - Next tail = (squash_idx+1) mod DEPTH.
  - Entries from squash_idx+1 to tail-1 are invalidated; squashed = (tail-squash_idx-1) mod DEPTH (0 if squash_idx=tail-1, including when full).
  - Same-cycle dispatch is dropped.
  - Retire proceeds normally; squash_idx must be valid or retiring this cycle.
- Count update: count_next = count + accepted_dispatch - retire_num - squashed.
- Wrap: all index arithmetic is mod DEPTH via natural IDX_W overflow. full/empty come from count, never from head==tail.
- Entry lifecycle: a single entry may be dispatched, completed and retired in the same cycle only on distinct slots. No bypass of completion into same-cycle retire.

Optional Feature:
- Macro ROB_PERF_EN. When defined, three extra 32-bit saturating outputs exist:
  - perf_retired: total entries retired.
  - perf_full_cycles: cycles with full=1.
  - perf_squashed: total entries squashed.
- All three reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
Configuration for all cases: DEPTH=8, DISPATCH_W=RETIRE_W=CDB_W=2.
- Reset: hold reset=0 -> free_slots=8, empty=1, full=0, retire_num=0.
- Fill to full: dispatch_num=2 for 4 cycles -> dispatch_idx {0,1},{2,3},{4,5},{6,7}; then full=1, free_slots=0; a 5th dispatch of 2 is rejected and state is unchanged.
- Out-of-order completion: complete idx1 -> retire_num stays 0; complete idx0 next cycle -> following cycle retire_num=2, retire_data = payload0, payload1; with retire_en=0 that cycle, retire_num=0 and entries are held.
- Wrap-around: steady state of 2 dispatched + 2 retired per cycle for 10 cycles -> indices wrap 7 to 0, FIFO order preserved, count constant.
- Squash: entries 0..5 valid; in one cycle squash_idx=2, dispatch_num=2, complete idx4 -> next cycle free_slots=5, tail=3, dispatch dropped, entry 4 invalid; the next dispatch receives idx 3,4 with complete=0.
- Reset mid-operation: drop reset asynchronously between clock edges while entries are valid -> outputs return to reset values immediately and no retire occurs at the next edge.
